// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_ADDR_W = 2;

  // Occupancy must represent 0..DEPTH inclusive, so one bit wider than a pointer.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO data/handshake bundle: producer/consumer side (master) and FIFO side (slave).
// Latency: n/a (wiring only).
// Backpressure: master observes fullp/emptyp and the sticky error flags.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);

  localparam int CNT_W = cnt_width(ADDR_W);

  logic [DATA_W-1:0] din;
  logic              writep;
  logic              readp;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              emptyp;
  logic              fullp;
  logic              almostemptyp;
  logic              almostfullp;
  logic [CNT_W-1:0]  count;
  logic              overflowp;
  logic              underflowp;

  modport master (
    output din, writep, readp,
    input  dout, dout_valid, emptyp, fullp, almostemptyp, almostfullp,
           count, overflowp, underflowp
  );

  modport slave (
    input  din, writep, readp,
    output dout, dout_valid, emptyp, fullp, almostemptyp, almostfullp,
           count, overflowp, underflowp
  );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port register array, DEPTH x DATA_W, for FIFO storage.
// Latency: write lands at the clock edge; read data registered, 1 cycle after re.
// Backpressure: none; the caller guarantees valid addresses and enables.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: written on we, intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port: holds its last value when re is low, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost flags, flush and sticky error flags.
// Latency: popped word appears on dout (with dout_valid) the cycle after an accepted read.
// Backpressure: writes rejected when full unless a read is accepted the same cycle; flags sticky.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = FIFO_DATA_W,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic              flushp,
  sync_fifo_param_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = cnt_width(ADDR_W);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [CNT_W-1:0]  cnt;
  logic              vld;
  logic              ovf;
  logic              unf;

  logic empty;
  logic full;
  logic rd_acc;
  logic wr_acc;
  logic rd_en;
  logic wr_en;

  // Status decodes of the registered count; glitch-free relative to clk.
  always_comb begin
    empty = (cnt == '0);
    full  = (cnt == DEPTH_C);
  end

  // Acceptance on registered state; a full FIFO still takes a write when a read drains it.
  // Reset and flush suppress any storage/pointer activity in that cycle.
  always_comb begin
    rd_acc = bus.readp & ~empty;
    wr_acc = bus.writep & (~full | rd_acc);
    rd_en  = rd_acc & ~flushp & ~rstp;
    wr_en  = wr_acc & ~flushp & ~rstp;
  end

  // Pointer, occupancy, valid strobe and sticky error state.
  always_ff @(posedge clk) begin
    if (rstp) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (flushp) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      vld  <= 1'b0;
    end else begin
      if (wr_acc) begin
        head <= head + 1'b1;
      end
      if (rd_acc) begin
        tail <= tail + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        cnt <= cnt + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        cnt <= cnt - 1'b1;
      end
      vld <= rd_acc;
      if (bus.writep && !wr_acc) begin
        ovf <= 1'b1;
      end
      if (bus.readp && empty) begin
        unf <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rstp),
    .we    (wr_en),
    .waddr (head),
    .wdata (bus.din),
    .re    (rd_en),
    .raddr (tail),
    .rdata (bus.dout)
  );

  // Drive the remaining status outputs from registered state.
  always_comb begin
    bus.dout_valid   = vld;
    bus.emptyp       = empty;
    bus.fullp        = full;
    bus.almostemptyp = (cnt <= AE_C);
    bus.almostfullp  = (cnt >= AF_C);
    bus.count        = cnt;
    bus.overflowp    = ovf;
    bus.underflowp   = unf;
  end

endmodule
